// File: rtl/octurdle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : octurdle_pkg
// Description : Shared types and helpers for the Octurdle round controller.
//               Round-state encoding, LFSR feedback taps and the per-digit
//               compare used by the guess evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package octurdle_pkg;

    // Encoding is visible on state_o and selects the display mode downstream,
    // so the numeric values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } round_state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Digits are at most 32 bits wide; callers zero-extend before comparing.
    function automatic logic digit_eq(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

endpackage : octurdle_pkg
`default_nettype wire

// File: rtl/octurdle_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : octurdle_lfsr32
// Description : Free-running 32-bit Galois LFSR used as the target source.
//               Advances every clock; the state can never become all-zero.
// Ports       : clk     - system clock
//               reset_n - asynchronous active-low reset (loads SEED)
//               q       - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module octurdle_lfsr32
    import octurdle_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] q
);

    // A zero seed would lock the register at zero forever; substitute 1.
    localparam logic [31:0] SAFE_SEED = (SEED == 32'd0) ? 32'd1 : SEED;

    // When the shifted-out bit is 1 the mask sets bit 31, so a non-zero state
    // always maps to a non-zero state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SAFE_SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_TAPS;
        end else begin
            q <= q >> 1;
        end
    end

endmodule : octurdle_lfsr32
`default_nettype wire

// File: rtl/octurdle_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : octurdle_round_ctrl
// Description : Round controller for the Octurdle guessing game. Latches a
//               random N-digit target, evaluates guesses with exact/present
//               feedback, counts tries, detects win/loss and keeps a
//               saturating score of rounds won.
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               enter      - debounced button level (rising edge = event)
//               guess      - NUM_DIGITS digits of DIGIT_W bits
//               target_o   - latched target
//               exact_o    - per-digit exact match
//               present_o  - per-digit "present elsewhere" match
//               tries_o    - guesses used this round
//               score_o    - rounds won since reset (saturating)
//               win_o      - one-cycle pulse on a winning check
//               lose_o     - one-cycle pulse when tries run out
//               state_o    - current round state
// Revision    : 1.0 - initial release
// ============================================================================
module octurdle_round_ctrl
    import octurdle_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter int          DIGIT_W    = 4,
    parameter int          MAX_TRIES  = 6,
    parameter int          SCORE_W    = 8,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enter,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    output logic [NUM_DIGITS*DIGIT_W-1:0] target_o,
    output logic [NUM_DIGITS-1:0]         exact_o,
    output logic [NUM_DIGITS-1:0]         present_o,
    output logic [3:0]                    tries_o,
    output logic [SCORE_W-1:0]            score_o,
    output logic                          win_o,
    output logic                          lose_o,
    output logic [2:0]                    state_o
);

    localparam int         W         = NUM_DIGITS * DIGIT_W;
    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    round_state_t          state;
    logic                  enter_q;
    logic                  enter_rise;
    logic [W-1:0]          guess_q;
    logic [31:0]           lfsr_q;
    logic [NUM_DIGITS-1:0] exact_c;
    logic [NUM_DIGITS-1:0] present_c;
    logic [3:0]            tries_next;

    octurdle_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    // Only the low W bits feed the target; keep the rest explicitly unused.
    generate
        if (W < 32) begin : g_lfsr_hi
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_q[31:W];
        end
    endgenerate

    assign enter_rise = enter & ~enter_q;
    assign tries_next = tries_o + 4'd1;
    assign state_o    = state;

    // Guess evaluation against the latched target. A target digit that is
    // already exactly matched cannot also satisfy "present" for another
    // position; duplicates are intentionally not de-duplicated.
    always_comb begin
        exact_c   = '0;
        present_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            exact_c[i] = digit_eq(32'(guess_q[i*DIGIT_W +: DIGIT_W]),
                                  32'(target_o[i*DIGIT_W +: DIGIT_W]));
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (!exact_c[i] && (j != i) && !exact_c[j] &&
                    digit_eq(32'(guess_q[i*DIGIT_W +: DIGIT_W]),
                             32'(target_o[j*DIGIT_W +: DIGIT_W]))) begin
                    present_c[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            enter_q   <= 1'b0;
            guess_q   <= '0;
            target_o  <= '0;
            exact_o   <= '0;
            present_o <= '0;
            tries_o   <= 4'd0;
            score_o   <= '0;
            win_o     <= 1'b0;
            lose_o    <= 1'b0;
        end else begin
            enter_q <= enter;
            win_o   <= 1'b0;
            lose_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enter_rise) state <= ST_GEN;
                end
                ST_GEN: begin
                    target_o  <= lfsr_q[W-1:0];
                    tries_o   <= 4'd0;
                    exact_o   <= '0;
                    present_o <= '0;
                    state     <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (enter_rise) begin
                        guess_q <= guess;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    exact_o   <= exact_c;
                    present_o <= present_c;
                    tries_o   <= tries_next;
                    if (&exact_c) begin
                        state <= ST_WIN;
                        win_o <= 1'b1;
                        if (score_o != {SCORE_W{1'b1}}) score_o <= score_o + 1'b1;
                    end else if (tries_next == TRY_LIMIT) begin
                        state  <= ST_LOSE;
                        lose_o <= 1'b1;
                    end else begin
                        state <= ST_PLAY;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (enter_rise) state <= ST_GEN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : octurdle_round_ctrl
`default_nettype wire

// File: tb/tb_octurdle_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_octurdle_round_ctrl
// Description : Directed self-checking bench for octurdle_round_ctrl.
//               Instance A: default geometry, seed chosen so the first
//               target is 16'h1234. Instance B: SCORE_W=2 for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_octurdle_round_ctrl;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // One step backwards through the Galois LFSR; bit 31 of the successor
    // reveals the shifted-out bit.
    function automatic logic [31:0] lfsr_prev(input logic [31:0] n);
        logic [31:0] t;
        if (n[31]) begin
            t = n ^ TAPS;
            return (t << 1) | 32'd1;
        end
        return n << 1;
    endfunction

    localparam logic [31:0] SEED_A = lfsr_prev(32'hC0DE_1234);
    localparam logic [31:0] SEED_B = 32'hACE1_2468;

    logic        clk;
    int          vectors;
    int          miscompares;

    // Instance A signals
    logic        reset_n_a, enter_a;
    logic [15:0] guess_a, target_a;
    logic [3:0]  exact_a, present_a, tries_a;
    logic [7:0]  score_a;
    logic        win_a, lose_a;
    logic [2:0]  state_a;

    // Instance B signals
    logic        reset_n_b, enter_b;
    logic [15:0] guess_b, target_b;
    logic [3:0]  exact_b, present_b, tries_b;
    logic [1:0]  score_b;
    logic        win_b, lose_b;
    logic [2:0]  state_b;

    octurdle_round_ctrl #(
        .NUM_DIGITS (4), .DIGIT_W (4), .MAX_TRIES (6), .SCORE_W (8), .LFSR_SEED (SEED_A)
    ) dut_a (
        .clk (clk), .reset_n (reset_n_a), .enter (enter_a), .guess (guess_a),
        .target_o (target_a), .exact_o (exact_a), .present_o (present_a),
        .tries_o (tries_a), .score_o (score_a), .win_o (win_a), .lose_o (lose_a),
        .state_o (state_a)
    );

    octurdle_round_ctrl #(
        .NUM_DIGITS (4), .DIGIT_W (4), .MAX_TRIES (6), .SCORE_W (2), .LFSR_SEED (SEED_B)
    ) dut_b (
        .clk (clk), .reset_n (reset_n_b), .enter (enter_b), .guess (guess_b),
        .target_o (target_b), .exact_o (exact_b), .present_o (present_b),
        .tries_o (tries_b), .score_o (score_b), .win_o (win_b), .lose_o (lose_b),
        .state_o (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial models running alongside each instance; the expected target
    // is the model value present on the edge that leaves GEN.
    logic [31:0] model_a, model_b;
    logic [15:0] exp_tgt_a, exp_tgt_b;

    always @(posedge clk or negedge reset_n_a)
        if (!reset_n_a) model_a <= SEED_A;
        else            model_a <= lfsr_next(model_a);

    always @(posedge clk or negedge reset_n_b)
        if (!reset_n_b) model_b <= SEED_B;
        else            model_b <= lfsr_next(model_b);

    always @(posedge clk) begin
        if (reset_n_a && state_a == 3'd1) exp_tgt_a <= model_a[15:0];
        if (reset_n_b && state_b == 3'd1) exp_tgt_b <= model_b[15:0];
    end

    // Reference feedback: exact per position, present if the guess digit
    // matches a different, not-exactly-matched target digit.
    function automatic void fb_model(input logic [15:0] g, input logic [15:0] t,
                                     output logic [3:0] ex, output logic [3:0] pr);
        for (int i = 0; i < 4; i++) ex[i] = (g[i*4 +: 4] == t[i*4 +: 4]);
        pr = 4'b0000;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!ex[i] && j != i && !ex[j] && g[i*4 +: 4] == t[j*4 +: 4]) pr[i] = 1'b1;
    endfunction

    // Called on a falling edge; returns two falling edges later, when the
    // registered result of the check is visible.
    task automatic pulse_a(input logic [15:0] g);
        guess_a = g;
        enter_a = 1'b1;
        @(negedge clk);
        enter_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        enter_a = 1'b0; enter_b = 1'b0;
        guess_a = 16'h0000; guess_b = 16'h0000;
        repeat (3) @(negedge clk);
        vectors++;
        if (state_a !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_a); end
        vectors++;
        if ({target_a, exact_a, present_a, tries_a, score_a} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: target %h exact %b present %b tries %0d score %0d, expected all zero",
                     target_a, exact_a, present_a, tries_a, score_a);
        end
        vectors++;
        if ({win_a, lose_a} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: win %b lose %b expected 0 0", win_a, lose_a); end
    endtask

    task automatic test_first_round;
        reset_n_a = 1'b1;
        enter_a   = 1'b1;
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd1) begin miscompares++; $display("FAIL first_gen_state: got %0d expected 1", state_a); end
        enter_a = 1'b0;
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd2) begin miscompares++; $display("FAIL first_play_state: got %0d expected 2", state_a); end
        vectors++;
        if (target_a !== exp_tgt_a) begin miscompares++; $display("FAIL first_target_model: got %h expected %h", target_a, exp_tgt_a); end
        vectors++;
        if (target_a !== 16'h1234) begin miscompares++; $display("FAIL first_target_value: got %h expected 1234", target_a); end
        vectors++;
        if ({tries_a, score_a} !== 12'd0) begin miscompares++; $display("FAIL first_counters: tries %0d score %0d expected 0 0", tries_a, score_a); end
    endtask

    task automatic test_partial_match;
        pulse_a(16'h4231);
        vectors++;
        if (exact_a !== 4'b0110) begin miscompares++; $display("FAIL partial_exact: got %b expected 0110", exact_a); end
        vectors++;
        if (present_a !== 4'b1001) begin miscompares++; $display("FAIL partial_present: got %b expected 1001", present_a); end
        vectors++;
        if (state_a !== 3'd2 || tries_a !== 4'd1) begin
            miscompares++; $display("FAIL partial_state_tries: state %0d tries %0d expected 2 1", state_a, tries_a);
        end
        vectors++;
        if ({win_a, lose_a} !== 2'b00) begin miscompares++; $display("FAIL partial_pulses: win %b lose %b expected 0 0", win_a, lose_a); end
    endtask

    task automatic test_win;
        pulse_a(16'h1234);
        vectors++;
        if (exact_a !== 4'b1111 || present_a !== 4'b0000) begin
            miscompares++; $display("FAIL win_feedback: exact %b present %b expected 1111 0000", exact_a, present_a);
        end
        vectors++;
        if (win_a !== 1'b1 || state_a !== 3'd4) begin miscompares++; $display("FAIL win_pulse_state: win %b state %0d expected 1 4", win_a, state_a); end
        vectors++;
        if (score_a !== 8'd1 || tries_a !== 4'd2) begin miscompares++; $display("FAIL win_score_tries: score %0d tries %0d expected 1 2", score_a, tries_a); end
        @(negedge clk);
        vectors++;
        if (win_a !== 1'b0 || state_a !== 3'd4 || exact_a !== 4'b1111) begin
            miscompares++; $display("FAIL win_hold: win %b state %0d exact %b expected 0 4 1111", win_a, state_a, exact_a);
        end
    endtask

    task automatic test_lose;
        logic [15:0] masks [6];
        logic [15:0] g;
        logic [3:0]  ex, pr;
        masks = '{16'hFFFF, 16'h1111, 16'h2222, 16'h4444, 16'h8421, 16'h1248};
        enter_a = 1'b1;
        @(negedge clk);
        enter_a = 1'b0;
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd2 || tries_a !== 4'd0 || exact_a !== 4'd0 || present_a !== 4'd0) begin
            miscompares++;
            $display("FAIL new_round_clear: state %0d tries %0d exact %b present %b expected 2 0 0000 0000",
                     state_a, tries_a, exact_a, present_a);
        end
        vectors++;
        if (target_a !== exp_tgt_a) begin miscompares++; $display("FAIL new_round_target: got %h expected %h", target_a, exp_tgt_a); end
        for (int i = 0; i < 6; i++) begin
            g = exp_tgt_a ^ masks[i];
            fb_model(g, exp_tgt_a, ex, pr);
            pulse_a(g);
            vectors++;
            if (exact_a !== ex || present_a !== pr) begin
                miscompares++; $display("FAIL lose_feedback[%0d]: exact %b present %b expected %b %b", i, exact_a, present_a, ex, pr);
            end
            vectors++;
            if (tries_a !== 4'(i + 1)) begin miscompares++; $display("FAIL lose_tries[%0d]: got %0d expected %0d", i, tries_a, i + 1); end
            vectors++;
            if (i < 5) begin
                if (state_a !== 3'd2 || lose_a !== 1'b0) begin
                    miscompares++; $display("FAIL lose_early[%0d]: state %0d lose %b expected 2 0", i, state_a, lose_a);
                end
            end else begin
                if (state_a !== 3'd5 || lose_a !== 1'b1 || score_a !== 8'd1) begin
                    miscompares++; $display("FAIL lose_final: state %0d lose %b score %0d expected 5 1 1", state_a, lose_a, score_a);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (lose_a !== 1'b0 || state_a !== 3'd5) begin miscompares++; $display("FAIL lose_one_cycle: lose %b state %0d expected 0 5", lose_a, state_a); end
    endtask

    // From LOSE, enter is raised and held: one rise starts GEN, the level
    // held through GEN and PLAY must not trigger a check.
    task automatic test_enter_hold_gen;
        enter_a = 1'b1;
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd1) begin miscompares++; $display("FAIL hold_gen_state: got %0d expected 1", state_a); end
        repeat (5) @(negedge clk);
        vectors++;
        if (state_a !== 3'd2 || tries_a !== 4'd0) begin
            miscompares++; $display("FAIL hold_no_check: state %0d tries %0d expected 2 0", state_a, tries_a);
        end
        enter_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_check;
        guess_a = 16'h0000;
        enter_a = 1'b1;
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd3) begin miscompares++; $display("FAIL midcheck_state: got %0d expected 3", state_a); end
        reset_n_a = 1'b0;
        enter_a   = 1'b0;
        #1;
        vectors++;
        if (state_a !== 3'd0 || {target_a, exact_a, present_a, tries_a, score_a} !== 36'd0) begin
            miscompares++;
            $display("FAIL async_reset: state %0d target %h exact %b present %b tries %0d score %0d expected all zero",
                     state_a, target_a, exact_a, present_a, tries_a, score_a);
        end
        @(negedge clk);
        vectors++;
        if (state_a !== 3'd0 || {win_a, lose_a} !== 2'b00) begin
            miscompares++; $display("FAIL reset_hold: state %0d win %b lose %b expected 0 0 0", state_a, win_a, lose_a);
        end
    endtask

    task automatic test_score_saturate;
        logic [1:0] exp_score [4];
        exp_score = '{2'd1, 2'd2, 2'd3, 2'd3};
        reset_n_b = 1'b1;
        enter_b   = 1'b1;
        @(negedge clk);
        enter_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            guess_b = exp_tgt_b;
            enter_b = 1'b1;
            @(negedge clk);
            enter_b = 1'b0;
            @(negedge clk);
            vectors++;
            if (win_b !== 1'b1 || state_b !== 3'd4 || score_b !== exp_score[k]) begin
                miscompares++;
                $display("FAIL sat_win[%0d]: win %b state %0d score %0d expected 1 4 %0d", k, win_b, state_b, score_b, exp_score[k]);
            end
            enter_b = 1'b1;
            @(negedge clk);
            enter_b = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_enter_held;
        int checks;
        checks  = 0;
        guess_b = exp_tgt_b ^ 16'hFFFF;
        enter_b = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (state_b == 3'd3) checks++;
        end
        enter_b = 1'b0;
        vectors++;
        if (checks !== 1) begin miscompares++; $display("FAIL held_checks: got %0d expected 1", checks); end
        vectors++;
        if (tries_b !== 4'd1 || state_b !== 3'd2 || score_b !== 2'd3) begin
            miscompares++; $display("FAIL held_state: tries %0d state %0d score %0d expected 1 2 3", tries_b, state_b, score_b);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_first_round;
        test_partial_match;
        test_win;
        test_lose;
        test_enter_hold_gen;
        test_reset_mid_check;
        test_score_saturate;
        test_enter_held;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_octurdle_round_ctrl
`default_nettype wire
